ram_dp_asym: RTL and testbench
==============================

# ram_dp_asym

Parametrised true dual-port RAM with independent narrow/wide port widths, one shared clock, a hardware clear sequencer and deterministic collision handling. It replaces per-size simulation RAM primitives in bit-stream buffers and sequencer memories, where a narrow port faces the serial logic and a wide port faces the bus. Both ports provide 1- or 2-cycle read latency, a selectable read-during-write mode, and a memory that reads INIT_VALUE everywhere after reset.

## Interface
- WIDTHA, 1: port A data width (bits)
- DEPTHA, 16384: port A depth (words)
- WIDTHB, 2: port B data width; max(WIDTHA,WIDTHB)/min(...) is a power of two, checked at elaboration
- WR_MODE, 0: same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- OUT_REG, 0: 1 adds an output pipeline register on both ports
- INIT_VALUE, 0: narrow-word value written by the clear sequencer
- Derived: DEPTHB = DEPTHA*WIDTHA/WIDTHB; AWA/AWB = CLOG2(DEPTHA/DEPTHB); RATIO = wide/narrow width; NWIDE = depth of the wider port

- CLK  in  1  single clock for both ports
- RST  in  1  synchronous, active-high reset
- ENA  in  1  port A enable
- WEA  in  1  port A write (qualified by ENA)
- ADDRA  in  AWA  port A word address
- DIA  in  WIDTHA  port A write data
- DOA  out  WIDTHA  port A read data
- ENB, WEB, ADDRB, DIB, DOB: same as above for port B, widths WIDTHB/AWB
- BUSY  out  1  clear sequencer active; user access ignored
- COLLISION  out  1  one-cycle pulse: write/write overlap occurred

## Operation
- Storage: an array of narrow words, maxDEPTH entries. The wide-port word at address W covers narrow addresses {W, i}, i = 0..RATIO-1. Lane i maps to bits [(i+1)*n-1 : i*n].
- FSM states: CLEAR and READY.
- RST → CLEAR, clear counter = 0.
- In CLEAR, write INIT_VALUE into one wide word per cycle. The counter increments each cycle.
- CLEAR → READY after counter NWIDE-1 is written. BUSY deasserts on the first READY cycle.
- RST asserted mid-operation restarts CLEAR from address 0 at any time.
- While BUSY: ENA/ENB are ignored, no user writes occur, DOA/DOB are held at 0, and COLLISION stays 0.
- Port access (READY): with EN=1 and WE=1, write DI at ADDR. With EN=1 and WE=0, read ADDR. With EN=0, DO holds its value.
- Same-port write, by WR_MODE:
  - READ_FIRST: DO = old contents.
  - WRITE_FIRST: DO = DI.
  - NO_CHANGE: DO holds.
- Cross-port read of a location the other port writes in the same cycle always returns old contents (read-first), in every mode.
- Write/write overlap (narrow-address ranges intersect, both ENx & WEx):
  - Port B data wins on the intersecting narrow words.
  - Non-intersecting lanes of the wider write are written normally.
  - COLLISION pulses 1 on the next cycle.
- Read/read on the same address: both ports return the data; no flag.

## Timing
- Reset values (registered in the cycle RST is sampled): DOA=0, DOB=0, COLLISION=0, BUSY=1. The output pipeline registers (OUT_REG=1) are also 0.
- Clear duration: BUSY is high for exactly NWIDE cycles after RST deasserts. The first user access is accepted in the cycle BUSY is low.
- Read latency: data on DO at edge N+1 after the EN sample at edge N (OUT_REG=0), or at edge N+2 (OUT_REG=1).
- Write: the new data is visible to either port's read issued in the next cycle.
- COLLISION: asserted for one cycle, one cycle after the offending edge. It is independent of OUT_REG.
- Back-to-back accesses on both ports are allowed every cycle. There are no stall states.

## Structure
- Shared include: CLOG2/max/min helpers (existing log2func include). Add WR_MODE constants READ_FIRST=0, WRITE_FIRST=1, NO_CHANGE=2 to a common ram_defs include.
- Sub-module ram_dp_asym_init: clear FSM plus counter, outputs BUSY, clear address and clear write strobe. The top handles the memory array, lane generate loop, write-priority mux, collision compare and output pipeline.

## Test plan
- Reset/clear (DEPTHA=64, WIDTHA=1, WIDTHB=2, INIT_VALUE=1): RST for 2 cycles → BUSY high for exactly 32 cycles. After that, reads on all A addresses return 1 and all B addresses return 2'b11. DOA/DOB stay 0 during BUSY.
- Width mapping: B writes 2'b10 to address 5 → A reads address 10 → 0 and address 11 → 1. A writes 1 to address 0 → B reads address 0 → 2'b01.
- Read-during-write, per WR_MODE (address 3 holds 0, write 1): READ_FIRST → DOA=0; WRITE_FIRST → DOA=1; NO_CHANGE → DOA keeps its prior value. With OUT_REG=1, each result arrives one cycle later.
- Collision: same cycle, A writes 0 to address 8 and B writes 2'b11 to address 4 → address 8 = 1, address 9 = 1, COLLISION=1 for one cycle. Same cycle, B reads address 4 while A writes address 9 → DOB = old contents, COLLISION=0.
- Mid-operation reset: fill memory with 0, run traffic, assert RST on clear count 10 of a later clear → clear restarts at 0 and BUSY lasts a full 32 cycles. All addresses then read INIT_VALUE, and writes issued during BUSY leave no trace.

Source files
------------

// File: rtl/ram_dp_asym_pkg.sv
// Shared helpers, read-during-write mode codes and clear-FSM state type for ram_dp_asym.
package ram_dp_asym_pkg;

  // Same-port read-during-write behaviour
  localparam int WR_READ_FIRST  = 0;
  localparam int WR_WRITE_FIRST = 1;
  localparam int WR_NO_CHANGE   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_dp_asym_init.sv
// Clear sequencer: after reset, walks every wide word once and requests an INIT write.
//
// State table:
//   state    | meaning
//   ST_CLEAR | writing INIT_VALUE into wide word cnt_q; user access blocked
//   ST_READY | clear done; memory available to both ports
module ram_dp_asym_init
  import ram_dp_asym_pkg::*;
#(
  parameter int NWIDE = 1,
  parameter int CW    = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [CW-1:0] clr_addr_o
);

  clr_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and clear counter registers; reset restarts the walk from word 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: leave CLEAR once the last wide word has been written
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(NWIDE - 1)) state_d = ST_READY;
    end
  end

  // Outputs: busy and clear strobe follow the registered state
  always_comb begin
    busy_o     = (state_q == ST_CLEAR);
    clr_we_o   = (state_q == ST_CLEAR);
    clr_addr_o = cnt_q;
  end

endmodule

// File: rtl/ram_dp_asym.sv
// True dual-port RAM with asymmetric port widths over a narrow-word array,
// hardware clear after reset, port-B-wins write collisions and a collision flag.
module ram_dp_asym
  import ram_dp_asym_pkg::*;
#(
  parameter  int WIDTHA     = 1,
  parameter  int DEPTHA     = 16384,
  parameter  int WIDTHB     = 2,
  parameter  int WR_MODE    = WR_READ_FIRST,
  parameter  int OUT_REG    = 0,
  parameter  int INIT_VALUE = 0,
  localparam int DEPTHB     = DEPTHA * WIDTHA / WIDTHB,
  localparam int AWA        = max_i(1, clog2(DEPTHA)),
  localparam int AWB        = max_i(1, clog2(DEPTHB))
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENA,
  input  logic              WEA,
  input  logic [AWA-1:0]    ADDRA,
  input  logic [WIDTHA-1:0] DIA,
  output logic [WIDTHA-1:0] DOA,
  input  logic              ENB,
  input  logic              WEB,
  input  logic [AWB-1:0]    ADDRB,
  input  logic [WIDTHB-1:0] DIB,
  output logic [WIDTHB-1:0] DOB,
  output logic              BUSY,
  output logic              COLLISION
);

  localparam int NW     = min_i(WIDTHA, WIDTHB);
  localparam int WW     = max_i(WIDTHA, WIDTHB);
  localparam int RATIO  = WW / NW;
  localparam int NDEPTH = max_i(DEPTHA, DEPTHB);
  localparam int NWIDE  = min_i(DEPTHA, DEPTHB);
  localparam int NAW    = max_i(1, clog2(NDEPTH));
  localparam int CW     = max_i(1, clog2(NWIDE));
  localparam int LA     = WIDTHA / NW;
  localparam int LB     = WIDTHB / NW;

  if (!is_pow2(RATIO) || (WW % NW) != 0) begin : g_bad_ratio
    $error("ram_dp_asym: wide/narrow width ratio must be a power of two");
  end

  logic [NW-1:0]     mem_q [NDEPTH];
  logic              busy;
  logic              clr_we;
  logic [CW-1:0]     clr_addr;
  logic              user_ok;
  logic              wr_a, wr_b, overlap;
  logic [WIDTHA-1:0] rd_a;
  logic [WIDTHB-1:0] rd_b;
  logic [WIDTHA-1:0] doa_q;
  logic [WIDTHB-1:0] dob_q;
  logic              collision_q;

  // Narrow-array address of one lane of a port word
  function automatic logic [NAW-1:0] lane_addr(input logic [NAW-1:0] base, input int lanes,
                                               input int lane);
    return base * NAW'(lanes) + NAW'(lane);
  endfunction

  ram_dp_asym_init #(
    .NWIDE (NWIDE),
    .CW    (CW)
  ) u_init (
    .clk_i      (CLK),
    .rst_i      (RST),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // User access qualification and write/write overlap (same wide word on both ports)
  always_comb begin
    user_ok = !busy && !RST;
    wr_a    = user_ok && ENA && WEA;
    wr_b    = user_ok && ENB && WEB;
    overlap = (NAW'(ADDRA) / NAW'(RATIO / LA)) == (NAW'(ADDRB) / NAW'(RATIO / LB));
  end

  // Asynchronous lane gather; registering it below gives read-first (old) data
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < LA; i++) rd_a[i*NW +: NW] = mem_q[lane_addr(NAW'(ADDRA), LA, i)];
    for (int i = 0; i < LB; i++) rd_b[i*NW +: NW] = mem_q[lane_addr(NAW'(ADDRB), LB, i)];
  end

  // Array writes: clear has priority; B lanes are written after A so B wins on overlap
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      for (int i = 0; i < RATIO; i++)
        mem_q[lane_addr(NAW'(clr_addr), RATIO, i)] <= NW'(INIT_VALUE);
    end else begin
      if (wr_a)
        for (int i = 0; i < LA; i++) mem_q[lane_addr(NAW'(ADDRA), LA, i)] <= DIA[i*NW +: NW];
      if (wr_b)
        for (int i = 0; i < LB; i++) mem_q[lane_addr(NAW'(ADDRB), LB, i)] <= DIB[i*NW +: NW];
    end
  end

  // Port A read register with same-port read-during-write selection
  always_ff @(posedge CLK) begin
    if (RST || busy) begin
      doa_q <= '0;
    end else if (ENA) begin
      if (!WEA || WR_MODE == WR_READ_FIRST) doa_q <= rd_a;
      else if (WR_MODE == WR_WRITE_FIRST)   doa_q <= DIA;
    end
  end

  // Port B read register with same-port read-during-write selection
  always_ff @(posedge CLK) begin
    if (RST || busy) begin
      dob_q <= '0;
    end else if (ENB) begin
      if (!WEB || WR_MODE == WR_READ_FIRST) dob_q <= rd_b;
      else if (WR_MODE == WR_WRITE_FIRST)   dob_q <= DIB;
    end
  end

  // Collision flag: one-cycle pulse after a write/write overlap
  always_ff @(posedge CLK) begin
    if (RST) collision_q <= 1'b0;
    else     collision_q <= wr_a && wr_b && overlap;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTHA-1:0] doa_p_q;
    logic [WIDTHB-1:0] dob_p_q;

    // Extra output stage on both ports
    always_ff @(posedge CLK) begin
      if (RST) begin
        doa_p_q <= '0;
        dob_p_q <= '0;
      end else begin
        doa_p_q <= doa_q;
        dob_p_q <= dob_q;
      end
    end

    assign DOA = doa_p_q;
    assign DOB = dob_p_q;
  end else begin : g_noreg
    assign DOA = doa_q;
    assign DOB = dob_q;
  end

  assign BUSY      = busy;
  assign COLLISION = collision_q;

endmodule

// File: tb/tb_ram_dp_asym.sv
// Bench for ram_dp_asym: three instances (read-first, write-first, no-change with
// output register) share one stimulus stream and are compared to a narrow-bit array model.
module tb_ram_dp_asym;

  localparam int NWIDE = 32;
  localparam bit INIT  = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ena, wea, enb, web;
  logic [5:0] addra;
  logic [0:0] dia;
  logic [4:0] addrb;
  logic [1:0] dib;

  logic [0:0] doa_rf, doa_wf, doa_nc;
  logic [1:0] dob_rf, dob_wf, dob_nc;
  logic       busy_rf, busy_wf, busy_nc;
  logic       col_rf, col_wf, col_nc;

  ram_dp_asym #(.WIDTHA(1), .DEPTHA(64), .WIDTHB(2), .WR_MODE(0), .OUT_REG(0), .INIT_VALUE(1))
  u_rf (.CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa_rf),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob_rf),
        .BUSY(busy_rf), .COLLISION(col_rf));

  ram_dp_asym #(.WIDTHA(1), .DEPTHA(64), .WIDTHB(2), .WR_MODE(1), .OUT_REG(0), .INIT_VALUE(1))
  u_wf (.CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa_wf),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob_wf),
        .BUSY(busy_wf), .COLLISION(col_wf));

  ram_dp_asym #(.WIDTHA(1), .DEPTHA(64), .WIDTHB(2), .WR_MODE(2), .OUT_REG(1), .INIT_VALUE(1))
  u_nc (.CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa_nc),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob_nc),
        .BUSY(busy_nc), .COLLISION(col_nc));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: memory as 64 narrow bits; expected outputs per read-during-write mode
  bit       mem_m [64];
  bit       busy_m;
  int       clr_m;
  bit       col_m;
  bit [0:0] doa1_m [3];
  bit [1:0] dob1_m [3];
  bit [0:0] doa2_m;
  bit [1:0] dob2_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare all instances
  task automatic step();
    bit       old_mem [64];
    bit [0:0] a_rd;
    bit [1:0] b_rd;
    logic [5:0] nb0, nb1;
    nb0     = {addrb, 1'b0};
    nb1     = {addrb, 1'b1};
    old_mem = mem_m;
    a_rd    = old_mem[addra];
    b_rd    = {old_mem[nb1], old_mem[nb0]};
    @(posedge clk);
    if (rst) begin
      busy_m = 1'b1;
      clr_m  = 0;
      col_m  = 1'b0;
      doa2_m = '0;
      dob2_m = '0;
      for (int m = 0; m < 3; m++) begin
        doa1_m[m] = '0;
        dob1_m[m] = '0;
      end
    end else begin
      doa2_m = doa1_m[2];
      dob2_m = dob1_m[2];
      if (busy_m) begin
        mem_m[6'(2 * clr_m)]     = INIT;
        mem_m[6'(2 * clr_m + 1)] = INIT;
        clr_m++;
        if (clr_m == NWIDE) busy_m = 1'b0;
        col_m = 1'b0;
        for (int m = 0; m < 3; m++) begin
          doa1_m[m] = '0;
          dob1_m[m] = '0;
        end
      end else begin
        col_m = ena && wea && enb && web && (addra[5:1] == addrb);
        if (ena && wea) mem_m[addra] = dia[0];
        if (enb && web) begin
          mem_m[nb0] = dib[0];
          mem_m[nb1] = dib[1];
        end
        for (int m = 0; m < 3; m++) begin
          if (ena) begin
            if (!wea || m == 0) doa1_m[m] = a_rd;
            else if (m == 1)    doa1_m[m] = dia;
          end
          if (enb) begin
            if (!web || m == 0) dob1_m[m] = b_rd;
            else if (m == 1)    dob1_m[m] = dib;
          end
        end
      end
    end
    #1;
    check("busy_rf", 32'(busy_rf), 32'(busy_m));
    check("busy_nc", 32'(busy_nc), 32'(busy_m));
    check("col_rf", 32'(col_rf), 32'(col_m));
    check("col_wf", 32'(col_wf), 32'(col_m));
    check("col_nc", 32'(col_nc), 32'(col_m));
    check("doa_rf", 32'(doa_rf), 32'(doa1_m[0]));
    check("doa_wf", 32'(doa_wf), 32'(doa1_m[1]));
    check("doa_nc", 32'(doa_nc), 32'(doa2_m));
    check("dob_rf", 32'(dob_rf), 32'(dob1_m[0]));
    check("dob_wf", 32'(dob_wf), 32'(dob1_m[1]));
    check("dob_nc", 32'(dob_nc), 32'(dob2_m));
  endtask

  task automatic drive(input logic ea, input logic wa, input logic [5:0] aa, input logic da,
                       input logic eb, input logic wb, input logic [4:0] ab,
                       input logic [1:0] db);
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    step();
  endtask

  // Random inputs; half the time both ports aim at the same wide word
  task automatic rand_in();
    ena = 1'($urandom_range(0, 1));
    wea = 1'($urandom_range(0, 1));
    enb = 1'($urandom_range(0, 1));
    web = 1'($urandom_range(0, 1));
    dia = 1'($urandom);
    dib = 2'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      addrb = 5'($urandom_range(0, 3));
      addra = {addrb, 1'($urandom_range(0, 1))};
    end else begin
      addra = 6'($urandom_range(0, 63));
      addrb = 5'($urandom_range(0, 31));
    end
  endtask

  // Count cycles BUSY stays high from the last reset edge, with junk traffic applied
  task automatic measure_clear(input string tag);
    int n;
    n = 0;
    while (busy_rf && n < 100) begin
      n++;
      rand_in();
      step();
    end
    check(tag, 32'(n), 32'(NWIDE));
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) drive(1, 0, 6'(a), 0, 1, 0, 5'(a / 2), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    ena = 0; wea = 0; addra = '0; dia = '0;
    enb = 0; web = 0; addrb = '0; dib = '0;
    step();
    step();
    rst = 1'b0;
    measure_clear("clear_len");
    read_all();

    // Width mapping
    drive(0, 0, 0, 0, 1, 1, 5, 2'b10);
    drive(1, 0, 10, 0, 0, 0, 0, 0);
    check("map_a10", 32'(doa_rf), 32'd0);
    drive(1, 0, 11, 0, 0, 0, 0, 0);
    check("map_a11", 32'(doa_rf), 32'd1);
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    check("map_b0", 32'(dob_rf), 32'd1);

    // Same-port read-during-write, port A: address 3 holds 0, prior DOA 0, write 1
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    drive(1, 0, 10, 0, 0, 0, 0, 0);
    drive(1, 1, 3, 1, 0, 0, 0, 0);
    check("rdw_a_rf", 32'(doa_rf), 32'd0);
    check("rdw_a_wf", 32'(doa_wf), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rdw_a_nc", 32'(doa_nc), 32'd0);

    // Port B: word 6 holds 00, prior DOB 11 (word 7 = init), write 10
    drive(0, 0, 0, 0, 1, 1, 6, 2'b00);
    drive(0, 0, 0, 0, 1, 0, 7, 2'b00);
    drive(0, 0, 0, 0, 1, 1, 6, 2'b10);
    check("rdw_b_rf", 32'(dob_rf), 32'd0);
    check("rdw_b_wf", 32'(dob_wf), 32'd2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rdw_b_nc", 32'(dob_nc), 32'd3);

    // Write/write collision: B wins on address 8
    drive(1, 1, 8, 0, 1, 1, 4, 2'b11);
    check("col_pulse", 32'(col_rf), 32'd1);
    drive(1, 0, 8, 0, 0, 0, 0, 0);
    check("col_clear", 32'(col_rf), 32'd0);
    check("col_a8", 32'(doa_rf), 32'd1);
    drive(1, 0, 9, 0, 0, 0, 0, 0);
    check("col_a9", 32'(doa_rf), 32'd1);
    drive(1, 1, 9, 0, 1, 0, 4, 0);
    check("xport_old", 32'(dob_rf), 32'd3);
    check("xport_nocol", 32'(col_rf), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rand_in();
      step();
    end

    // Mid-operation reset: zero the memory, run traffic, reset again at clear count 10
    for (int b = 0; b < 32; b++) drive(0, 0, 0, 0, 1, 1, 5'(b), 2'b00);
    read_all();
    for (int i = 0; i < 200; i++) begin
      rand_in();
      step();
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_in();
      step();
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    measure_clear("clear_len_restart");
    read_all();
    drive(1, 0, 0, 0, 1, 0, 31, 0);
    check("restart_a0", 32'(doa_rf), 32'd1);
    check("restart_b31", 32'(dob_rf), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
